// File: rtl/booth_pkg.sv
// booth_pkg
// Shared definitions for the radix-4 Booth decode / accumulate block:
// digit encoding, operand and result widths, FSM states and a small
// sign-extension helper used where the 16-bit product meets the 24-bit
// result path.
package booth_pkg;

  localparam int DIGIT_W    = 3;
  localparam int NUM_DIGITS = 4;
  localparam int MCAND_W    = 8;
  localparam int PP_W       = MCAND_W + 1;
  localparam int PROD_W     = 16;
  localparam int RES_W      = 24;

  // Digit codes are {neg,two,one}; 3'b100 is a negative zero and is legal.
  localparam logic [DIGIT_W-1:0] B_ZERO = 3'b000;
  localparam logic [DIGIT_W-1:0] B_P1   = 3'b001;
  localparam logic [DIGIT_W-1:0] B_P2   = 3'b010;
  localparam logic [DIGIT_W-1:0] B_M1   = 3'b101;
  localparam logic [DIGIT_W-1:0] B_M2   = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Widen a signed product to the result width by replicating its sign bit.
  function automatic logic [RES_W-1:0] sextProd(input logic [PROD_W-1:0] p);
    return {{(RES_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// booth_r4_pp_gen
// Decodes one radix-4 Booth digit and produces the matching partial product
// in "ones-complement plus carry" form: the selected M or 2M (9 bits, sign
// extended) is inverted for negative digits and the neg bit is handed back
// as a carry-in, so the accumulator adder performs the subtraction without a
// dedicated subtractor. Illegal codes (one and two both set) select zero and
// raise o_illegal.
module booth_r4_pp_gen
  import booth_pkg::*;
(
  input  logic [MCAND_W-1:0] i_mcand,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [PP_W-1:0]    o_ppInv,
  output logic               o_cin,
  output logic               o_illegal
);

  logic [PP_W-1:0] w_m1;
  logic [PP_W-1:0] w_m2;
  logic [PP_W-1:0] w_sel;
  logic            w_neg;

  assign w_m1 = {i_mcand[MCAND_W-1], i_mcand};
  assign w_m2 = {i_mcand, 1'b0};

  // Pick the magnitude (0, M or 2M) and sign for this digit; a negative zero
  // is treated as a plain zero so it never injects a stray carry.
  always_comb begin
    w_sel     = '0;
    w_neg     = 1'b0;
    o_illegal = 1'b0;
    case (i_digit)
      B_ZERO, 3'b100: begin
        w_sel = '0;
        w_neg = 1'b0;
      end
      B_P1: w_sel = w_m1;
      B_P2: w_sel = w_m2;
      B_M1: begin
        w_sel = w_m1;
        w_neg = 1'b1;
      end
      B_M2: begin
        w_sel = w_m2;
        w_neg = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_ppInv = w_sel ^ {PP_W{w_neg}};
  assign o_cin   = w_neg;

endmodule

// File: rtl/booth_r4_decode_acc.sv
// booth_r4_decode_acc
// Multi-cycle radix-4 Booth multiplier driven by pre-decoded digits. An
// operand pair is accepted in IDLE, the four digits are folded into a 16-bit
// signed product one per cycle in ACC, and the result is presented in DONE
// until the consumer takes it. err is a sticky illegal-digit flag.
// Optional feature: define MACC_ACCUM_EN to add a 24-bit accumulator so that
// result = acc + product, with acc updated on each output handshake and
// cleared by acc_clr while idle. Without it acc_clr is ignored.
module booth_r4_decode_acc
  import booth_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [MCAND_W-1:0]              mcand,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [RES_W-1:0]                result,
  output logic                            err,
  input  logic                            acc_clr
);

  state_t                          r_state;
  logic [1:0]                      r_cnt;
  logic [MCAND_W-1:0]              r_mcand;
  logic [NUM_DIGITS*DIGIT_W-1:0]   r_digits;
  logic [PROD_W-1:0]               r_prod;
  logic                            r_inReady;
  logic                            r_outValid;
  logic                            r_err;

  logic [DIGIT_W-1:0]              w_digit;
  logic [PP_W-1:0]                 w_ppInv;
  logic                            w_cin;
  logic                            w_illegal;
  logic [PROD_W-1:0]               w_ppExt;
  logic [PROD_W-1:0]               w_cinExt;
  logic [PROD_W-1:0]               w_prodNext;
  logic [2:0]                      w_shift;

  assign w_digit = r_digits[DIGIT_W*r_cnt +: DIGIT_W];
  assign w_shift = {r_cnt, 1'b0};

  booth_r4_pp_gen u_ppGen (
    .i_mcand   (r_mcand),
    .i_digit   (w_digit),
    .o_ppInv   (w_ppInv),
    .o_cin     (w_cin),
    .o_illegal (w_illegal)
  );

  // Shifting the inverted partial product and its carry by the same amount
  // keeps the two's-complement identity -(x<<s) = (~x<<s) + (1<<s) intact.
  assign w_ppExt    = {{(PROD_W-PP_W){w_ppInv[PP_W-1]}}, w_ppInv} << w_shift;
  assign w_cinExt   = {{(PROD_W-1){1'b0}}, w_cin} << w_shift;
  assign w_prodNext = r_prod + w_ppExt + w_cinExt;

  // Control FSM with registered handshake outputs; the operand registers are
  // captured only on acceptance so later input changes have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_digits   <= '0;
      r_prod     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_inReady) begin
            r_mcand   <= mcand;
            r_digits  <= digits;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_inReady <= 1'b0;
            r_state   <= S_ACC;
          end
        end
        S_ACC: begin
          r_prod <= w_prodNext;
          r_cnt  <= r_cnt + 2'd1;
          if (w_illegal) begin
            r_err <= 1'b1;
          end
          if (r_cnt == 2'd3) begin
            r_outValid <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign err       = r_err;

`ifdef MACC_ACCUM_EN
  logic [RES_W-1:0] r_acc;

  // Running sum of delivered results; a clear while idle wins over folding
  // in a product, and any simultaneous operand acceptance still happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if ((r_state == S_IDLE) && acc_clr) begin
      r_acc <= '0;
    end else if ((r_state == S_DONE) && out_ready) begin
      r_acc <= r_acc + sextProd(r_prod);
    end
  end

  assign result = r_acc + sextProd(r_prod);
`else
  logic w_unused;

  assign w_unused = acc_clr;
  assign result   = sextProd(r_prod);
`endif

endmodule

// File: tb/tb_booth_r4_decode_acc.sv
// tb_booth_r4_decode_acc
// Scoreboard bench for booth_r4_decode_acc. The driver computes the expected
// result from the Booth digit values with plain integer arithmetic and pushes
// it on acceptance; an independent monitor pops and compares on every output
// handshake. Build with MACC_ACCUM_EN defined to exercise the accumulator.
module tb_booth_r4_decode_acc;

  typedef struct packed {
    logic [23:0] res;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mcand;
  logic [11:0] digits;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] result;
  logic        err;
  logic        acc_clr;

  exp_t        sbQ[$];
  int          nChecks = 0;
  int          nFails  = 0;
  bit          modelErr = 1'b0;
  int          modelAcc = 0;
  logic [2:0]  legalCodes[6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b110};

  booth_r4_decode_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .digits    (digits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .acc_clr   (acc_clr)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Value of one Booth digit by its meaning, independent of any encoding trick.
  function automatic int digitValue(input logic [2:0] code, output bit illegal);
    illegal = 1'b0;
    case (code)
      3'b000, 3'b100: return 0;
      3'b001:         return 1;
      3'b010:         return 2;
      3'b101:         return -1;
      3'b110:         return -2;
      default: begin
        illegal = 1'b1;
        return 0;
      end
    endcase
  endfunction

  function automatic int modelProduct(input logic [7:0] m, input logic [11:0] d,
                                      output bit anyIllegal);
    int sum = 0;
    int weight = 1;
    bit ill;
    anyIllegal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] code = d[3*i +: 3];
      sum += digitValue(code, ill) * $signed(m) * weight;
      anyIllegal |= ill;
      weight *= 4;
    end
    return sum;
  endfunction

  function automatic logic [11:0] randomDigits(input bit allowIllegal);
    logic [11:0] d;
    for (int i = 0; i < 4; i++) begin
      if (allowIllegal && ($urandom_range(0, 7) == 0))
        d[3*i +: 3] = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b011;
      else
        d[3*i +: 3] = legalCodes[$urandom_range(0, 5)];
    end
    return d;
  endfunction

  // One complete operation: offer operands, check latency and hold behaviour,
  // then let the consumer take the result after holdCycles stalled cycles.
  task automatic applyStimulus(input logic [7:0] m, input logic [11:0] d,
                               input int holdCycles, input bit clr);
    exp_t e;
    int   prod;
    bit   ill;
    int   guard = 0;
    @(posedge clk); #1;
    mcand     = m;
    digits    = d;
    in_valid  = 1'b1;
    acc_clr   = clr;
    out_ready = (holdCycles == 0);
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      acc_clr  = 1'b0;
      return;
    end
    prod = modelProduct(m, d, ill);
    modelErr |= ill;
`ifdef MACC_ACCUM_EN
    if (clr) modelAcc = 0;
    e.res    = 24'(modelAcc + prod);
    modelAcc = modelAcc + prod;
`else
    e.res = 24'(prod);
`endif
    e.err = modelErr;
    sbQ.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    mcand    = 8'($urandom);
    digits   = 12'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("latency_low", 32'(out_valid), 32'd0);
      checkOutput("busy_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    checkOutput("latency_valid", 32'(out_valid), 32'd1);
    for (int h = 1; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_result", 32'(result), 32'(e.res));
      checkOutput("hold_ready", 32'(in_ready), 32'd0);
    end
    if (holdCycles > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic pulseReset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst      = 1'b0;
    modelErr = 1'b0;
    modelAcc = 0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
  endtask

  // Monitor: every output handshake must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput("result", 32'(result), 32'(e.res));
          checkOutput("err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  // Main sequence: reset, directed vectors, random operations, abort, errors.
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    mcand     = '0;
    digits    = '0;
    out_ready = 1'b1;
    acc_clr   = 1'b0;
    $display("[TB] start");
    pulseReset(3);

    applyStimulus(8'd5, 12'h00D, 0, 1'b0);
    pulseReset(1);
    applyStimulus(8'h80, 12'hC00, 0, 1'b0);
    pulseReset(1);
    applyStimulus(8'd127, 12'h492, 0, 1'b0);
    pulseReset(1);
    applyStimulus(8'hFF, 12'h492, 5, 1'b0);
    pulseReset(1);

    for (int i = 0; i < 30; i++) begin
`ifdef MACC_ACCUM_EN
      applyStimulus(8'($urandom), randomDigits(1'b0), $urandom_range(0, 2), 1'b0);
`else
      applyStimulus(8'($urandom), randomDigits(1'b0), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)));
`endif
    end

    // Abort mid-ACC: no result may ever appear for this operation.
    @(posedge clk); #1;
    mcand    = 8'd9;
    digits   = 12'h492;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    pulseReset(1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
    end

    applyStimulus(8'd5, 12'h00B, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(8'($urandom), randomDigits(1'b0), 0, 1'b0);
    @(negedge clk);
    checkOutput("err_sticky", 32'(err), 32'd1);
    pulseReset(1);

    for (int i = 0; i < 15; i++)
      applyStimulus(8'($urandom), randomDigits(1'b1), $urandom_range(0, 1), 1'b0);

`ifdef MACC_ACCUM_EN
    pulseReset(1);
    applyStimulus(8'd5, 12'h00D, 0, 1'b0);
    applyStimulus(8'd5, 12'h00D, 0, 1'b0);
    @(posedge clk); #1;
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr  = 1'b0;
    modelAcc = 0;
    applyStimulus(8'd5, 12'h00D, 0, 1'b0);
    applyStimulus(8'd5, 12'h00D, 0, 1'b1);
`endif

    repeat (4) @(negedge clk);
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/booth_r4_decode_acc.md
BOOTH_R4_DECODE_ACC -- requirements
Module: booth_r4_decode_acc

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  operand request; in_ready  output  1  block can accept.
REQ-004 SHALL have ports: mcand  input  8  signed two's-complement multiplicand.
REQ-005 SHALL have ports: digits  input  12  four radix-4 Booth digits {d3,d2,d1,d0}, 3 bits each as {neg,two,one}.
REQ-006 SHALL have ports: out_valid  output  1  result available; out_ready  input  1  consumer accepts.
REQ-007 SHALL have ports: result  output  24  signed result; err  output  1  sticky illegal-digit flag; acc_clr  input  1  clear accumulator.

Function
REQ-008 SHALL decode each digit: 000/100=0, 001=+1, 010=+2, 101=-1, 110=-2; 011 and 111 are illegal, contribute 0, and set err.
REQ-009 SHALL form the partial product by selecting M or 2M (9-bit sign-extended), inverting on neg, and adding neg as carry-in; no separate subtractor.
REQ-010 SHALL run FSM IDLE -> ACC -> DONE -> IDLE.
REQ-011 SHALL assert in_ready only in IDLE and latch mcand and digits on in_valid&&in_ready, clearing the product register and setting cnt=0.
REQ-012 SHALL, in ACC, on each edge add pp(d[cnt]) << (2*cnt) into a 16-bit signed product and increment cnt; at the edge where cnt==3 go to DONE.
REQ-013 SHALL assert out_valid exactly 4 cycles after the accept edge and hold result stable until out_valid&&out_ready, then return to IDLE.
REQ-014 SHALL not overlap operations; throughput is one operation per 6 cycles minimum, and in_ready stays low during ACC and DONE.
REQ-015 SHALL ignore input changes after the accept edge.
REQ-016 SHALL make err sticky until rst, and evaluate it per digit during ACC.
REQ-017 SHALL not overflow: the product range is within ±21760 and fits 16 bits signed.

Reset
REQ-018 SHALL, on rst, force state IDLE, cnt=0, product=0, accumulator=0, result=0, out_valid=0, err=0, in_ready=1 on the next cycle.
REQ-019 SHALL abort any ACC or DONE operation on rst with no result delivered, and rst SHALL override acc_clr and handshakes in the same cycle.

Configuration
REQ-020 SHALL, with MACC_ACCUM_EN defined, keep a 24-bit signed accumulator with result = acc + sign-extended product; acc updates on the output handshake edge, and acc_clr in IDLE zeroes acc (priority over a simultaneous in handshake, which still proceeds).
REQ-021 SHALL, without MACC_ACCUM_EN, keep acc_clr as a port but ignore it, and make result the sign-extended product with no accumulator register.

Structure
REQ-022 SHALL place the following in the shared package booth_pkg: digit width, the digit codes (B_ZERO, B_P1, B_P2, B_M1, B_M2), the digit count (4), the product and result widths, and the FSM state enum.
REQ-023 SHALL implement per-digit decode plus partial-product generation (select, invert, carry-in) in sub-module booth_r4_pp_gen.

Verification
REQ-024 SHALL verify: mcand=5, digits=12'h00D -> out_valid 4 cycles after accept, result=15, err=0.
REQ-025 SHALL verify: mcand=-128, digits=12'hC00 -> result=16384 (0x004000).
REQ-026 SHALL verify: mcand=127, digits=12'h492 -> result=21590, and mcand=-1 with the same digits -> result=-170 (24'hFFFF56).
REQ-027 SHALL verify: digits with d0=011, mcand=5 -> d0 contributes 0, err=1, and err stays 1 over later legal operations until rst.
REQ-028 SHALL verify: out_ready held low for 5 cycles -> result and out_valid held and in_ready=0, then return to IDLE on the first out_ready edge; rst pulsed mid-ACC -> IDLE, no out_valid, outputs zero.
REQ-029 SHALL verify, with MACC_ACCUM_EN: two ops of 15 -> results 15 then 30, then acc_clr -> next op result 15.
